// File: rtl/axi_ad7124_pwr_seq_if.sv
// axi_ad7124_pwr_seq_if: request levels from the register block and sequencer status back to it
// Ports (signals):
//   ctrl_power_en   - power request level (1 = on)
//   ctrl_relay_ctrl - relay request level (1 = calibration, 0 = normal)
//   sts_ready       - supply stable, relay in position, no sequence running
//   sts_relay_pos   - last relay position actually driven
//   sts_state       - current sequencer state code
// Modports: master = register block side, slave = sequencer side.
interface axi_ad7124_pwr_seq_if;
    logic       ctrl_power_en;
    logic       ctrl_relay_ctrl;
    logic       sts_ready;
    logic       sts_relay_pos;
    logic [2:0] sts_state;
    modport master (
        output ctrl_power_en, ctrl_relay_ctrl,
        input  sts_ready, sts_relay_pos, sts_state
    );
    modport slave (
        input  ctrl_power_en, ctrl_relay_ctrl,
        output sts_ready, sts_relay_pos, sts_state
    );
endinterface

// File: rtl/axi_ad7124_pwr_seq.sv
// axi_ad7124_pwr_seq: power/reset/latching-relay sequencer for the AD7124 front end
// Ports:
//   up_clk, up_rstn - clock and asynchronous active-low reset
//   bus             - request levels in, status out (slave modport)
//   pwr_en          - load-switch enable
//   adc_rst_n       - ADC reset, active low
//   relay_set       - coil drive toward calibration position
//   relay_rst       - coil drive toward normal position
module axi_ad7124_pwr_seq #(
    parameter int PWR_SETTLE_CYCLES   = 100000,
    parameter int RELAY_PULSE_CYCLES  = 1000000,
    parameter int RELAY_SETTLE_CYCLES = 500000,
    parameter int PWR_OFF_CYCLES      = 200000
) (
    input  logic                       up_clk,
    input  logic                       up_rstn,
    axi_ad7124_pwr_seq_if.slave        bus,
    output logic                       pwr_en,
    output logic                       adc_rst_n,
    output logic                       relay_set,
    output logic                       relay_rst
);
    localparam int MAX_A = (PWR_SETTLE_CYCLES > RELAY_PULSE_CYCLES) ? PWR_SETTLE_CYCLES : RELAY_PULSE_CYCLES;
    localparam int MAX_B = (RELAY_SETTLE_CYCLES > PWR_OFF_CYCLES) ? RELAY_SETTLE_CYCLES : PWR_OFF_CYCLES;
    localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAXP > 1) ? $clog2(MAXP) : 1;
    localparam logic [CW-1:0] PS_LD = CW'(PWR_SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] RP_LD = CW'(RELAY_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] RS_LD = CW'(RELAY_SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] PO_LD = CW'(PWR_OFF_CYCLES - 1);
    typedef enum logic [2:0] {
        OFF          = 3'd0,
        PWR_SETTLE   = 3'd1,
        RELAY_PULSE  = 3'd2,
        RELAY_SETTLE = 3'd3,
        READY        = 3'd4,
        PWR_DOWN     = 3'd5
    } state_t;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          target, target_n;
    logic          pos, pos_n;
    logic          done;
    logic          pe, rc;
    logic          pwr_en_n, adc_rst_n_n, relay_set_n, relay_rst_n, ready_n;
    assign pe = bus.ctrl_power_en;
    assign rc = bus.ctrl_relay_ctrl;
    always_comb begin
        done     = (cnt == '0);
        state_n  = state;
        cnt_n    = done ? cnt : cnt - CW'(1);
        target_n = target;
        pos_n    = pos;
        case (state)
            OFF:
                if (pe) begin
                    state_n = PWR_SETTLE;
                    cnt_n   = PS_LD;
                end
            PWR_SETTLE:
                if (!pe) begin
                    state_n = PWR_DOWN;
                    cnt_n   = PO_LD;
                end else if (done) begin
                    // forced pulse: relay position is unknown after power loss
                    state_n  = RELAY_PULSE;
                    cnt_n    = RP_LD;
                    target_n = rc;
                    pos_n    = rc;
                end
            RELAY_PULSE:
                if (done) begin
                    state_n = RELAY_SETTLE;
                    cnt_n   = RS_LD;
                end
            RELAY_SETTLE:
                if (!pe) begin
                    state_n = PWR_DOWN;
                    cnt_n   = PO_LD;
                end else if (done) begin
                    if (rc != target) begin
                        state_n  = RELAY_PULSE;
                        cnt_n    = RP_LD;
                        target_n = rc;
                        pos_n    = rc;
                    end else begin
                        state_n = READY;
                    end
                end
            READY:
                if (!pe) begin
                    state_n = PWR_DOWN;
                    cnt_n   = PO_LD;
                end else if (rc != pos) begin
                    state_n  = RELAY_PULSE;
                    cnt_n    = RP_LD;
                    target_n = rc;
                    pos_n    = rc;
                end
            PWR_DOWN:
                if (done) state_n = OFF;
            default: begin
                state_n = OFF;
                cnt_n   = '0;
            end
        endcase
        // outputs decoded from the next state so they move with the state register
        pwr_en_n    = (state_n == PWR_SETTLE) || (state_n == RELAY_PULSE) ||
                      (state_n == RELAY_SETTLE) || (state_n == READY);
        adc_rst_n_n = (state_n == RELAY_PULSE) || (state_n == RELAY_SETTLE) || (state_n == READY);
        relay_set_n = (state_n == RELAY_PULSE) && target_n;
        relay_rst_n = (state_n == RELAY_PULSE) && !target_n;
        ready_n     = (state_n == READY);
    end
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state             <= OFF;
            cnt               <= '0;
            target            <= 1'b0;
            pos               <= 1'b0;
            pwr_en            <= 1'b0;
            adc_rst_n         <= 1'b0;
            relay_set         <= 1'b0;
            relay_rst         <= 1'b0;
            bus.sts_ready     <= 1'b0;
            bus.sts_relay_pos <= 1'b0;
            bus.sts_state     <= 3'd0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            target            <= target_n;
            pos               <= pos_n;
            pwr_en            <= pwr_en_n;
            adc_rst_n         <= adc_rst_n_n;
            relay_set         <= relay_set_n;
            relay_rst         <= relay_rst_n;
            bus.sts_ready     <= ready_n;
            bus.sts_relay_pos <= pos_n;
            bus.sts_state     <= state_n;
        end
    end
endmodule
